// File: rtl/bit_sampler.sv
// Mid-bit serial sampler: re-aligns on every input edge, samples at half period,
// assembles MSB-first words onto a valid/ready output. Majority voting via BIT_SAMPLER_MAJORITY_EN.
module bit_sampler #(
  parameter int unsigned CLK_LEN  = 16,
  parameter int unsigned WORD_LEN = 8,
  parameter int unsigned SYNC_LEN = 2,
  parameter int unsigned MAX_RUN  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signal,
  input  logic [CLK_LEN-1:0]  bit_period,
  input  logic                period_valid,
  output logic                bit_out,
  output logic                bit_strobe,
  output logic [WORD_LEN-1:0] word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic                locked,
  output logic                overflow
);

`ifdef BIT_SAMPLER_MAJORITY_EN
  localparam int unsigned MIN_PERIOD = 4;
`else
  localparam int unsigned MIN_PERIOD = 2;
`endif
  localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);
  localparam int unsigned BIT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [RUN_W-1:0]   RUN_LIMIT = RUN_W'(MAX_RUN);
  localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(WORD_LEN - 1);
  localparam logic [CLK_LEN-1:0] PERIOD_MIN = CLK_LEN'(MIN_PERIOD);

  typedef enum logic [1:0] {IDLE, HUNT, TRACK} state_t;

  state_t               state;
  logic [SYNC_LEN-1:0]  sync_q;
  logic                 s_sync;
  logic                 s_prev;
  logic                 edge_det;
  logic [CLK_LEN-1:0]   period_q;
  logic [CLK_LEN-1:0]   ph;
  logic [CLK_LEN-1:0]   half;
  logic                 ph_last;
  logic [RUN_W-1:0]     run_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [WORD_LEN-1:0]  sh;
  logic                 word_done;
  logic                 period_ok;
  logic                 input_ok;
  logic                 sample_evt;
  logic                 sample_bit;
`ifdef BIT_SAMPLER_MAJORITY_EN
  logic [1:0]           maj_q;
`endif

  assign s_sync    = sync_q[SYNC_LEN-1];
  assign edge_det  = s_sync != s_prev;
  assign half      = period_q >> 1;
  assign ph_last   = ph == (period_q - CLK_LEN'(1));
  assign period_ok = period_q >= PERIOD_MIN;
  assign input_ok  = period_valid && (bit_period >= PERIOD_MIN);

  // An edge in the same cycle always wins, so no sample is taken on a realignment cycle.
`ifdef BIT_SAMPLER_MAJORITY_EN
  assign sample_evt = (state == TRACK) && !edge_det && (ph == half + CLK_LEN'(1));
  assign sample_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & s_sync) | (maj_q[1] & s_sync);
`else
  assign sample_evt = (state == TRACK) && !edge_det && (ph == half);
  assign sample_bit = s_sync;
`endif

  // NOTE: every register below uses <= so all branches read pre-edge values consistently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync_q     <= '0;
      s_prev     <= 1'b0;
      period_q   <= '0;
      ph         <= '0;
      run_cnt    <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      word_done  <= 1'b0;
      bit_out    <= 1'b0;
      bit_strobe <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      overflow   <= 1'b0;
`ifdef BIT_SAMPLER_MAJORITY_EN
      maj_q      <= '0;
`endif
    end else begin
      sync_q     <= {sync_q[SYNC_LEN-2:0], signal};
      s_prev     <= s_sync;
      bit_strobe <= 1'b0;

      // Output register: a completed word lands one cycle after its final strobe.
      if (word_valid && word_ready) word_valid <= 1'b0;
      if (word_done) begin
        word_done <= 1'b0;
        if (!word_valid || word_ready) begin
          word_out   <= sh;
          word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (edge_det) period_q <= bit_period;

      case (state)
        IDLE: begin
          // Track the live period while idle so the validity check has a real value on entry to HUNT.
          period_q <= bit_period;
          if (input_ok) state <= HUNT;
        end

        HUNT: begin
          if (!period_valid || !period_ok) begin
            state   <= IDLE;
            ph      <= '0;
            run_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
          end else if (edge_det) begin
            state   <= TRACK;
            locked  <= 1'b1;
            ph      <= '0;
            run_cnt <= '0;
            bit_cnt <= '0;
          end
        end

        TRACK: begin
          if (!period_valid || !period_ok) begin
            state   <= IDLE;
            locked  <= 1'b0;
            ph      <= '0;
            run_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
          end else if (edge_det) begin
            ph      <= '0;
            run_cnt <= '0;
          end else begin
            ph <= ph_last ? '0 : ph + CLK_LEN'(1);
`ifdef BIT_SAMPLER_MAJORITY_EN
            if (ph == half - CLK_LEN'(1)) maj_q[0] <= s_sync;
            if (ph == half)               maj_q[1] <= s_sync;
`endif
            if (sample_evt) begin
              if (run_cnt + RUN_W'(1) == RUN_LIMIT) begin
                // Too long without an edge: drop this sample and the partial word.
                state   <= HUNT;
                locked  <= 1'b0;
                run_cnt <= '0;
                bit_cnt <= '0;
                sh      <= '0;
              end else begin
                run_cnt    <= run_cnt + RUN_W'(1);
                bit_out    <= sample_bit;
                bit_strobe <= 1'b1;
                sh         <= {sh[WORD_LEN-2:0], sample_bit};
                if (bit_cnt == LAST_BIT) begin
                  bit_cnt   <= '0;
                  word_done <= 1'b1;
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_sampler.sv
// Directed bench for bit_sampler: lock, word assembly, backpressure, run-length loss,
// period invalidation, edge/sample collision and mid-operation reset.
module tb_bit_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signal = 1'b0;
  logic [15:0] bit_period = 16'd20;
  logic        period_valid = 1'b1;
  logic        bit_out;
  logic        bit_strobe;
  logic [7:0]  word_out;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic        locked;
  logic        overflow;

  int n_vec  = 0;
  int n_fail = 0;

  int cyc = 0;
  int strobe_cnt, first_strobe_cyc, last_strobe_cyc;
  int word_cnt, valid_cycles;
  logic [7:0] last_word;
  logic prev_valid = 1'b0;
  int p_ref;

  bit_sampler #(.CLK_LEN(16), .WORD_LEN(8), .SYNC_LEN(2), .MAX_RUN(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .signal       (signal),
    .bit_period   (bit_period),
    .period_valid (period_valid),
    .bit_out      (bit_out),
    .bit_strobe   (bit_strobe),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .locked       (locked),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles, sampling outputs 1 time unit after each rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bit_strobe) begin
        if (strobe_cnt == 0) first_strobe_cyc = cyc;
        strobe_cnt++;
        last_strobe_cyc = cyc;
      end
      if (word_valid && !prev_valid) begin
        word_cnt++;
        last_word = word_out;
      end
      if (word_valid) valid_cycles++;
      prev_valid = word_valid;
    end
  endtask

  task automatic clear_stats();
    strobe_cnt = 0;
    first_strobe_cyc = -1;
    last_strobe_cyc = -1;
    word_cnt = 0;
    valid_cycles = 0;
  endtask

  task automatic do_reset();
    signal = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] pat, input int nbits, input int len);
    for (int i = nbits - 1; i >= 0; i--) begin
      signal = pat[i];
      step(len);
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_bit_out",    bit_out,    0);
    check("rst_bit_strobe", bit_strobe, 0);
    check("rst_word_out",   word_out,   0);
    check("rst_word_valid", word_valid, 0);
    check("rst_locked",     locked,     0);
    check("rst_overflow",   overflow,   0);
    rst = 1'b0;

    // Basic lock and word 0xAA, period 20
    clear_stats();
    step(5);
    signal = 1'b1;
    p_ref = cyc;
    step(2);
    check("lock_before", locked, 0);
    step(1);
    check("lock_after", locked, 1);
    step(17);
    send_bits(16'h002A, 7, 20);
    check("basic_latency", first_strobe_cyc - p_ref, 14);
    check("basic_strobes", strobe_cnt, 8);
    check("basic_words",   word_cnt, 1);
    check("basic_word",    last_word, 8'hAA);
    check("basic_vcycles", valid_cycles, 1);

    // Backpressure: 0xF0 held, 0x0F dropped
    do_reset();
    word_ready = 1'b0;
    step(3);
    clear_stats();
    send_bits(16'hF00F, 16, 20);
    check("bp_strobes",  strobe_cnt, 16);
    check("bp_valid",    word_valid, 1);
    check("bp_word",     word_out, 8'hF0);
    check("bp_overflow", overflow, 1);
    word_ready = 1'b1;
    step(1);
    check("bp_drop_valid", word_valid, 0);
    check("bp_ovf_sticky", overflow, 1);
    word_ready = 1'b0;
    send_bits(16'h0055, 8, 20);
    check("bp2_valid", word_valid, 1);
    check("bp2_word",  word_out, 8'h55);
    check("bp2_ovf",   overflow, 1);
    check("bp2_bit",   bit_out, 1);

    // Mid-operation reset
    do_reset();
    check("mrst_bit_out",    bit_out,    0);
    check("mrst_bit_strobe", bit_strobe, 0);
    check("mrst_word_out",   word_out,   0);
    check("mrst_word_valid", word_valid, 0);
    check("mrst_locked",     locked,     0);
    check("mrst_overflow",   overflow,   0);

    // Run-length loss, period 10
    word_ready = 1'b1;
    bit_period = 16'd10;
    step(3);
    clear_stats();
    signal = 1'b1;
    p_ref = cyc;
    step(200);
    check("run_strobes", strobe_cnt, 15);
    check("run_first",   first_strobe_cyc - p_ref, 9);
    check("run_last",    last_strobe_cyc - p_ref, 149);
    check("run_locked",  locked, 0);
    check("run_words",   word_cnt, 1);
    check("run_word",    last_word, 8'hFF);
    clear_stats();
    send_bits(16'h0055, 8, 10);
    step(5);
    check("run_relock_words", word_cnt, 1);
    check("run_relock_word",  last_word, 8'h55);
    check("run_relock_lock",  locked, 1);

    // Period invalid mid-word
    bit_period = 16'd20;
    do_reset();
    step(3);
    clear_stats();
    send_bits(16'h0005, 3, 20);
    check("inv_strobes3", strobe_cnt, 3);
    check("inv_locked3",  locked, 1);
    period_valid = 1'b0;
    step(2);
    check("inv_unlocked", locked, 0);
    step(5);
    period_valid = 1'b1;
    step(3);
    send_bits(16'h005A, 8, 20);
    step(5);
    check("inv_strobes", strobe_cnt, 11);
    check("inv_words",   word_cnt, 1);
    check("inv_word",    last_word, 8'h5A);

    // Edge lands exactly on the sample point (ph == 10)
    do_reset();
    step(3);
    clear_stats();
    signal = 1'b1;
    p_ref = cyc;
    step(11);
    signal = 1'b0;
    p_ref = cyc;
    step(13);
    check("coll_no_strobe", strobe_cnt, 0);
    step(1);
    check("coll_strobe",   bit_strobe, 1);
    check("coll_latency",  first_strobe_cyc - p_ref, 14);
    check("coll_bit",      bit_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_sampler.md
Name: bit_sampler

Overview:
- Downstream consumer of the clock-recovery stage. Takes the raw serial `signal` and the measured minimum pulse interval `bit_period`, which is the recovered `clk_freq` count in base-clock ticks.
- Re-aligns its sampling phase on every input edge and samples each bit at mid-period.
- Assembles bits MSB-first into words and hands them out on a valid/ready interface.
- Runs in the 300 MHz global base-clock domain.

Parameters:
- CLK_LEN, 16: width of `bit_period` and the internal phase counter.
- WORD_LEN, 8: bits per output word.
- SYNC_LEN, 2: synchronizer flop stages on `signal`; minimum 2.
- MAX_RUN, 16: number of consecutive samples without an input edge that forces loss of lock.

Ports:
- clk  in  1  base clock (300 MHz global).
- rst  in  1  synchronous, active-high reset.
- signal  in  1  asynchronous serial input.
- bit_period  in  CLK_LEN  ticks per bit, from the clock-recovery stage.
- period_valid  in  1  high when `bit_period` is trustworthy.
- bit_out  out  1  last sampled bit value.
- bit_strobe  out  1  one-cycle pulse when `bit_out` updates.
- word_out  out  WORD_LEN  assembled word; first-received bit is the MSB.
- word_valid  out  1  `word_out` holds an unconsumed word.
- word_ready  in  1  consumer accepts the word.
- locked  out  1  high in TRACK state.
- overflow  out  1  sticky: a completed word was dropped.

Behaviour:
- **Reset values.** Synchronous active-high reset, single clock (`clk`). On reset, all outputs are 0, the state is IDLE, and all counters and the shift register are cleared. Reset asserted mid-word discards the partial word and clears `overflow`.
- **Input conditioning.** `signal` passes through SYNC_LEN flops to give `s_sync`. An edge is `s_sync != s_prev`, where `s_prev` is a one-cycle-delayed copy.
- **Period snapshot.** `period_q` latches `bit_period` on every edge. `period_q < 2` counts as invalid.
- **States:**
  - IDLE → HUNT when `period_valid` is high and `bit_period >= 2`.
  - HUNT → TRACK on the first edge. On that edge: `ph <= 0`, bit count 0, run count 0.
  - TRACK → HUNT when the run count reaches MAX_RUN. The partial word is cleared.
  - Any state → IDLE when `period_valid` is low or `period_q < 2`. The partial word is cleared.
- **Phase counter `ph`** (CLK_LEN bits, active in TRACK):
  - An edge forces `ph <= 0`.
  - Otherwise `ph` wraps to 0 when `ph == period_q - 1`, else increments.
  - An edge takes priority over wrap and over sampling in the same cycle; no sample is taken that cycle.
- **Sampling.**
  - A sample event occurs when `ph == period_q >> 1` and there is no edge in that cycle.
  - On a sample event, `bit_out <= s_sync` and `bit_strobe` pulses on the following cycle.
  - The run count increments on each sample and is cleared on each edge.
  - If the increment makes the run count equal MAX_RUN, that sample is discarded: no strobe, and the state goes to HUNT.
  - Net effect: at most MAX_RUN-1 identical bits are accepted between edges.
- **Word assembly.**
  - Each accepted bit shifts into `sh` MSB-first and the bit count increments.
  - At WORD_LEN bits, the bit count resets to 0 and the word is offered to the output register:
    - If `word_valid` is 0, or `word_valid && word_ready` in the same cycle: load `word_out` and set `word_valid` one cycle after the final bit's strobe.
    - Otherwise, drop the word and set `overflow` (cleared only by `rst`).
- **Output handshake.** `word_valid` holds until `word_valid && word_ready`, then drops the next cycle unless a new word loads in that same cycle. `word_out` is stable while `word_valid && !word_ready`.
- **Latency.** From an edge at the pin to the first `bit_strobe`: SYNC_LEN + 1 + (`period_q >> 1`) + 1 cycles.
- **Width rule.** All comparisons are unsigned CLK_LEN-bit. `ph` never exceeds `period_q - 1`.

Optional Feature:
- Macro BIT_SAMPLER_MAJORITY_EN.
- **Defined:**
  - The sampled bit is the majority of `s_sync` at `ph = half-1`, `half`, `half+1`, with the decision taken at `half+1`.
  - `bit_strobe` is therefore one cycle later than without the feature.
  - Requires `period_q >= 4`; smaller values count as invalid and the block goes to IDLE.
  - An edge inside the 3-tick window aborts that sample.
- **Undefined:** single sample at `ph == period_q >> 1` as above; the minimum valid period is 2.

Test Plan:
- **Basic lock and word.** `bit_period=20`, `period_valid=1`, `signal` 0 then toggling every 20 cycles starting high, word_ready=1 → `locked` rises on first edge; first strobe 10+SYNC_LEN+2 cycles after the pin edge; `word_out=0xAA` with `word_valid` for 1 cycle.
- **Backpressure.** `bit_period=20`, `word_ready=0`, stream pattern 0xF0 then 0x0F → first word is held with `word_out=0xF0`; second word dropped, `overflow=1`; `word_out` still 0xF0. Raise `word_ready` → `word_valid` falls; `overflow` stays 1.
- **Run-length loss.** `bit_period=10`, MAX_RUN=16, one edge then constant level for 200 cycles → 15 strobes, then `locked=0`, no further strobes, partial word discarded.
- **Period invalid.** Drop `period_valid` mid-word (after 3 bits) → state IDLE, `locked=0`. Restore it and send 8 fresh bits 0x5A → `word_out=0x5A`, earlier 3 bits absent.
- **Edge/sample collision.** `bit_period=20`, inject an edge exactly at `ph=10` → no strobe that cycle, `ph` restarts at 0, next strobe 10 cycles later.
- **Mid-operation reset.** Assert `rst` one cycle while `word_valid=1` and `overflow=1` → next cycle all outputs 0, state IDLE.
